uart_rx_byte: RTL and testbench

UART_RX_BYTE -- requirements
Module: uart_rx_byte

---
 rtl/uart_rx_byte.sv | 132 +++++++++++++
 tb/tb_uart_rx_byte.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: samples each bit at mid-period, flags a bad stop bit as a framing error.
// Returns to IDLE in the middle of the stop bit, so a back-to-back start edge is caught.
module uart_rx_byte #(
   parameter int Fclk = 50000000,
   parameter int VEL  = 57600,
   parameter int Nt   = Fclk / VEL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       URXD,
   output logic [7:0] dat,
   output logic       ok_rx,
   output logic       fr_err,
   output logic       en_rx_byte,
   output logic [3:0] cb_bit,
   output logic       ce_tact
);

   localparam logic [15:0] NT_C  = 16'(Nt);
   localparam logic [15:0] NT2_C = 16'(Nt / 2);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic        rx_m_q, rx_s_q, rx_p_q;
   logic [1:0]  state_q, state_d;
   logic [15:0] cb_tact_q, cb_tact_d;
   logic [3:0]  cb_bit_q, cb_bit_d;
   logic [7:0]  sr_dat_q, sr_dat_d;
   logic [7:0]  dat_q, dat_d;
   logic        ok_rx_q, ok_rx_d;
   logic        fr_err_q, fr_err_d;

   always_comb begin
      state_d   = state_q;
      cb_tact_d = cb_tact_q;
      cb_bit_d  = cb_bit_q;
      sr_dat_d  = sr_dat_q;
      dat_d     = dat_q;
      ok_rx_d   = 1'b0;
      fr_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cb_tact_d = 16'd0;
            // A line held low (break) never re-triggers: a real high-to-low edge is required.
            if (rx_p_q && !rx_s_q) begin
               state_d   = START;
               cb_tact_d = 16'd1;
               cb_bit_d  = 4'd0;
            end
         end
         START: begin
            if (cb_tact_q == NT2_C) begin
               if (!rx_s_q) begin
                  state_d   = DATA;
                  cb_tact_d = 16'd1;
               end else begin
                  state_d   = IDLE;
                  cb_tact_d = 16'd0;
               end
            end else begin
               cb_tact_d = cb_tact_q + 16'd1;
            end
         end
         DATA: begin
            if (cb_tact_q == NT_C) begin
               sr_dat_d  = {rx_s_q, sr_dat_q[7:1]};
               cb_bit_d  = cb_bit_q + 4'd1;
               cb_tact_d = 16'd1;
               if (cb_bit_q == 4'd7) state_d = STOP;
            end else begin
               cb_tact_d = cb_tact_q + 16'd1;
            end
         end
         STOP: begin
            if (cb_tact_q == NT_C) begin
               if (rx_s_q) begin
                  dat_d   = sr_dat_q;
                  ok_rx_d = 1'b1;
               end else begin
                  fr_err_d = 1'b1;
               end
               state_d   = IDLE;
               cb_tact_d = 16'd0;
            end else begin
               cb_tact_d = cb_tact_q + 16'd1;
            end
         end
         default: begin
            state_d   = IDLE;
            cb_tact_d = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m_q    <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_p_q    <= 1'b1;
         state_q   <= IDLE;
         cb_tact_q <= 16'd0;
         cb_bit_q  <= 4'd0;
         sr_dat_q  <= 8'd0;
         dat_q     <= 8'd0;
         ok_rx_q   <= 1'b0;
         fr_err_q  <= 1'b0;
      end else begin
         rx_m_q    <= URXD;
         rx_s_q    <= rx_m_q;
         rx_p_q    <= rx_s_q;
         state_q   <= state_d;
         cb_tact_q <= cb_tact_d;
         cb_bit_q  <= cb_bit_d;
         sr_dat_q  <= sr_dat_d;
         dat_q     <= dat_d;
         ok_rx_q   <= ok_rx_d;
         fr_err_q  <= fr_err_d;
      end
   end

   assign dat        = dat_q;
   assign ok_rx      = ok_rx_q;
   assign fr_err     = fr_err_q;
   assign en_rx_byte = (state_q != IDLE);
   assign cb_bit     = cb_bit_q;
   assign ce_tact    = ((state_q == START) && (cb_tact_q == NT2_C)) ||
                       (((state_q == DATA) || (state_q == STOP)) && (cb_tact_q == NT_C));

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: serial frames are driven bit by bit while a monitor
// pops expected strobes from a queue and compares them as the receiver reports.
module tb_uart_rx_byte;

   localparam int NT = 868;

   logic       clk;
   logic       rst;
   logic       URXD;
   logic [7:0] dat;
   logic       ok_rx;
   logic       fr_err;
   logic       en_rx_byte;
   logic [3:0] cb_bit;
   logic       ce_tact;

   typedef struct {
      bit         err;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks  = 0;
   int   n_err     = 0;
   int   n_pushed  = 0;
   int   n_strobes = 0;
   int   ce_cnt    = 0;

   uart_rx_byte #(.Fclk(50000000), .VEL(57600), .Nt(NT)) dut (
      .clk       (clk),
      .rst       (rst),
      .URXD      (URXD),
      .dat       (dat),
      .ok_rx     (ok_rx),
      .fr_err    (fr_err),
      .en_rx_byte(en_rx_byte),
      .cb_bit    (cb_bit),
      .ce_tact   (ce_tact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input int per);
      URXD = b;
      repeat (per) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input int per, input logic stopv);
      send_bit(1'b0, per);
      for (int i = 0; i < 8; i++) send_bit(d[i], per);
      send_bit(stopv, per);
   endtask

   task automatic push_exp(input bit err, input logic [7:0] d);
      exp_t e;
      e.err  = err;
      e.data = d;
      exp_q.push_back(e);
      n_pushed++;
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      bit   prev_strobe;
      prev_strobe = 1'b0;
      forever begin
         @(negedge clk);
         if (ok_rx || fr_err) begin
            check("strobe_width", int'(prev_strobe), 0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_strobe: ok_rx=%0b fr_err=%0b dat=%0h, expected no strobe",
                        ok_rx, fr_err, dat);
            end else begin
               e = exp_q.pop_front();
               n_strobes++;
               check("strobe_kind", int'({ok_rx, fr_err}), e.err ? 2 'b01 : 2'b10);
               check("dat_at_strobe", int'(dat), int'(e.data));
               check("en_rx_byte_at_strobe", int'(en_rx_byte), 0);
               if (!e.err) check("cb_bit_at_ok", int'(cb_bit), 8);
            end
         end
         prev_strobe = ok_rx || fr_err;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (ce_tact) ce_cnt++;
      end
   end

   initial begin
      int  ce0;
      bit  en_seen;
      logic [7:0] rbyte;

      URXD = 1'b1;
      rst  = 1'b1;
      idle(5);
      check("reset_dat", int'(dat), 0);
      check("reset_ok_rx", int'(ok_rx), 0);
      check("reset_fr_err", int'(fr_err), 0);
      check("reset_en_rx_byte", int'(en_rx_byte), 0);
      check("reset_cb_bit", int'(cb_bit), 0);
      check("reset_ce_tact", int'(ce_tact), 0);
      rst = 1'b0;
      idle(20);

      // Clean frame 0xA5
      push_exp(1'b0, 8'hA5);
      ce0 = ce_cnt;
      send_byte(8'hA5, NT, 1'b1);
      idle(50);
      check("a5_ce_pulses", ce_cnt - ce0, 10);
      check("a5_en_low", int'(en_rx_byte), 0);
      check("a5_dat", int'(dat), 8'hA5);

      // Start-bit glitch of 100 clocks
      URXD = 1'b0;
      idle(10);
      check("glitch_start_entered", int'(en_rx_byte), 1);
      idle(90);
      URXD = 1'b1;
      idle(500);
      check("glitch_back_to_idle", int'(en_rx_byte), 0);
      check("glitch_dat_kept", int'(dat), 8'hA5);

      // Framing error, then line held low
      push_exp(1'b1, 8'hA5);
      send_byte(8'h3C, NT, 1'b0);
      en_seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (en_rx_byte) en_seen = 1'b1;
      end
      check("break_no_retrigger", int'(en_seen), 0);
      URXD = 1'b1;
      idle(50);
      check("ferr_en_low", int'(en_rx_byte), 0);
      check("ferr_dat_kept", int'(dat), 8'hA5);

      // Back-to-back frames, no idle gap
      push_exp(1'b0, 8'h00);
      push_exp(1'b0, 8'hFF);
      send_byte(8'h00, NT, 1'b1);
      send_byte(8'hFF, NT, 1'b1);
      idle(50);
      check("b2b_dat", int'(dat), 8'hFF);

      // Reset in the middle of data bit 4
      rbyte = 8'h5A;
      send_bit(1'b0, NT);
      for (int i = 0; i < 4; i++) send_bit(rbyte[i], NT);
      URXD = rbyte[4];
      idle(NT / 2);
      check("midframe_busy", int'(en_rx_byte), 1);
      rst = 1'b1;
      idle(1);
      check("midrst_en", int'(en_rx_byte), 0);
      check("midrst_cb_bit", int'(cb_bit), 0);
      check("midrst_dat", int'(dat), 0);
      check("midrst_ok_rx", int'(ok_rx), 0);
      check("midrst_fr_err", int'(fr_err), 0);
      check("midrst_ce_tact", int'(ce_tact), 0);
      rst  = 1'b0;
      URXD = 1'b1;
      idle(1000);

      push_exp(1'b0, 8'h81);
      send_byte(8'h81, NT, 1'b1);
      idle(50);
      check("after_rst_dat", int'(dat), 8'h81);

      // Sender bit period -2% and +2%
      push_exp(1'b0, 8'h55);
      send_byte(8'h55, 851, 1'b1);
      idle(50);
      check("slow_clk_dat", int'(dat), 8'h55);
      URXD = 1'b1;
      idle(20);
      push_exp(1'b0, 8'h55);
      send_byte(8'h55, 885, 1'b1);
      idle(100);
      check("fast_clk_dat", int'(dat), 8'h55);

      check("scoreboard_empty", exp_q.size(), 0);
      check("strobe_count", n_strobes, n_pushed);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
